// File: rtl/madd_issue_sched_pkg.sv
// Shared types and constants for the MADD issue scheduler.
//   DATA_W     : operand/result width of the MADD unit
//   TAG_ID_W   : id field width carried in a pipeline tag (upper bound on ID_W)
//   madd_tag_t : one tag pipe stage {valid, id}
//   clog2      : ceiling log2 for elaboration-time sizing
package madd_sched_pkg;

  localparam int DATA_W   = 32;
  localparam int TAG_ID_W = 8;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } madd_tag_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/madd_issue_sched_if.sv
// Requester/response bus of the MADD issue scheduler.
//   req_valid/req_ready : per-requester handshake, ready is a one-hot grant
//   req_a/b/c           : packed operands, requester i at [32i+31:32i]
//   rsp_valid/rsp_ready : response handshake
//   rsp_z/rsp_id        : result and originating requester
// master = requesters + response consumer, slave = scheduler.
interface madd_issue_sched_if #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
);

  logic [NREQ-1:0]                         req_valid;
  logic [NREQ-1:0]                         req_ready;
  logic [NREQ*madd_sched_pkg::DATA_W-1:0]  req_a;
  logic [NREQ*madd_sched_pkg::DATA_W-1:0]  req_b;
  logic [NREQ*madd_sched_pkg::DATA_W-1:0]  req_c;
  logic                                    rsp_valid;
  logic                                    rsp_ready;
  logic [madd_sched_pkg::DATA_W-1:0]       rsp_z;
  logic [ID_W-1:0]                         rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_c, rsp_ready,
    input  req_ready, rsp_valid, rsp_z, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, rsp_ready,
    output req_ready, rsp_valid, rsp_z, rsp_id
  );

endinterface

// File: rtl/madd_issue_sched_fifo.sv
// Synchronous response FIFO for MADD results.
//   clk, rst   : clock, async active-high reset (empties FIFO, clears storage)
//   push/data  : write {z, id} at end of cycle
//   pop        : remove head when valid
//   valid/head : head entry, stable until popped
//   count      : occupancy, feeds the scheduler's credit check
module madd_rsp_fifo
  import madd_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34,
  localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1,
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid  = (cnt != '0);
  assign full   = (cnt == CNT_W'(DEPTH));
  assign head   = mem[rd_ptr];
  assign count  = cnt;
  assign pop_ok = pop & valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Credits keep this unreachable; push+pop on a full FIFO is legal.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop_ok));

endmodule

// File: rtl/madd_issue_sched.sv
// Round-robin issue scheduler sharing one fixed-latency MADD (Z = A*B + C).
//   clk, rst       : clock, async active-high reset
//   bus (slave)    : requester operands/handshake and response stream
//   madd_a/b/c     : operands to MADD, held at last issued values when idle
//   madd_z         : MADD result, valid LAT cycles after operands
// Issue is credit-limited so every result in flight has a FIFO slot;
// the MADD pipeline is never stalled.
module madd_issue_sched
  import madd_sched_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int ID_W       = 2,
  parameter int LAT        = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  madd_issue_sched_if.slave bus,
  output logic [DATA_W-1:0] madd_a,
  output logic [DATA_W-1:0] madd_b,
  output logic [DATA_W-1:0] madd_c,
  input  logic [DATA_W-1:0] madd_z
);

  localparam int CNT_W = clog2(FIFO_DEPTH + 1);

  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   cand;
  logic              gnt_found;
  logic              issue_ok;
  logic              hs;
  int                credits_used;
  madd_tag_t         tag_q [LAT];
  logic [DATA_W-1:0] sel_a, sel_b, sel_c;
  logic [DATA_W-1:0] last_a, last_b, last_c;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W+ID_W-1:0] fifo_head;

  // Every op issued but not yet popped holds a credit: in the tag pipe or in the FIFO.
  always_comb begin
    credits_used = int'(fifo_count);
    for (int s = 0; s < LAT; s++) credits_used += int'(tag_q[s].valid);
    issue_ok = (credits_used < FIFO_DEPTH);
  end

  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NREQ);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  // Reset gates the grant so nothing handshakes while rst is high.
  assign hs            = gnt_found & issue_ok & ~rst;
  assign bus.req_ready = hs ? (NREQ'(1) << gnt_id) : '0;

  assign sel_a  = bus.req_a[gnt_id*DATA_W +: DATA_W];
  assign sel_b  = bus.req_b[gnt_id*DATA_W +: DATA_W];
  assign sel_c  = bus.req_c[gnt_id*DATA_W +: DATA_W];
  assign madd_a = hs ? sel_a : last_a;
  assign madd_b = hs ? sel_b : last_b;
  assign madd_c = hs ? sel_c : last_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      last_a <= '0;
      last_b <= '0;
      last_c <= '0;
      for (int s = 0; s < LAT; s++) tag_q[s] <= '0;
    end else begin
      if (hs) begin
        rr_ptr <= (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        last_a <= sel_a;
        last_b <= sel_b;
        last_c <= sel_c;
      end
      tag_q[0] <= '{valid: hs, id: TAG_ID_W'(gnt_id)};
      for (int s = 1; s < LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  // The last tag stage lines up with madd_z of the same op.
  madd_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + ID_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_q[LAT-1].valid),
    .push_data ({madd_z, ID_W'(tag_q[LAT-1].id)}),
    .pop       (bus.rsp_ready),
    .valid     (bus.rsp_valid),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign bus.rsp_z  = fifo_head[DATA_W+ID_W-1:ID_W];
  assign bus.rsp_id = fifo_head[ID_W-1:0];

endmodule

// File: tb/tb_madd_issue_sched.sv
module tb_madd_issue_sched;
  import madd_sched_pkg::*;

  localparam int NREQ = 4, ID_W = 2, LAT = 1, FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] madd_a, madd_b, madd_c, madd_z;

  madd_issue_sched_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

  madd_issue_sched #(.NREQ(NREQ), .ID_W(ID_W), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .madd_a(madd_a), .madd_b(madd_b), .madd_c(madd_c), .madd_z(madd_z)
  );

  always #5 clk = ~clk;

  // Behavioural MADD: fixed LAT-cycle pipeline
  logic [31:0] zp [LAT];
  always @(posedge clk) begin
    zp[0] <= madd_a * madd_b + madd_c;
    for (int s = 1; s < LAT; s++) zp[s] <= zp[s-1];
  end
  assign madd_z = zp[LAT-1];

  typedef struct { logic [31:0] z; int id; int cyc; } exp_t;
  typedef struct { int id; logic [31:0] a, b, c, z; } vec_t;

  exp_t sb[$];
  int   pop_ids[$];
  int   total = 0, bad = 0, cyc = 0, m_rr = 0;
  logic [31:0] m_last_a = '0, m_last_b = '0, m_last_c = '0;
  logic [NREQ*32-1:0] a_pk, b_pk, c_pk;
  logic [NREQ-1:0] o_rdy;
  logic o_rv, o_hs, o_pop;
  logic [31:0] o_z;
  logic [ID_W-1:0] o_id;
  int o_gid;

  function automatic logic [31:0] ref_madd(input logic [31:0] a, b, c);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b)) + longint'($signed(c));
    return p[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, compare against the queue-based model, update model.
  task automatic step(input logic [NREQ-1:0] v, input logic rdy);
    int g;
    logic [NREQ-1:0] exp_rdy;
    logic exp_rv;
    exp_t e;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_a = a_pk; bus.req_b = b_pk; bus.req_c = c_pk;
    bus.rsp_ready = rdy;
    #1;
    g = -1;
    if (sb.size() < FIFO_DEPTH)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && v[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    o_rdy = bus.req_ready;
    check("req_ready", o_rdy, exp_rdy);
    exp_rv = (sb.size() > 0) && (cyc >= sb[0].cyc + LAT + 1);
    o_rv = bus.rsp_valid; o_z = bus.rsp_z; o_id = bus.rsp_id;
    check("rsp_valid", o_rv, exp_rv);
    o_pop = o_rv && rdy;
    if (o_pop && sb.size() > 0) begin
      check("rsp_z", o_z, sb[0].z);
      check("rsp_id", o_id, sb[0].id);
      pop_ids.push_back(int'(o_id));
      void'(sb.pop_front());
    end
    o_gid = -1;
    for (int i = 0; i < NREQ; i++) if (v[i] && o_rdy[i]) o_gid = i;
    o_hs = (o_gid >= 0);
    if (o_hs) begin
      m_last_a = a_pk[o_gid*32 +: 32];
      m_last_b = b_pk[o_gid*32 +: 32];
      m_last_c = c_pk[o_gid*32 +: 32];
      e.z = ref_madd(m_last_a, m_last_b, m_last_c);
      e.id = o_gid; e.cyc = cyc;
      sb.push_back(e);
      m_rr = (o_gid + 1) % NREQ;
    end
    check("madd_a", madd_a, m_last_a);
    check("madd_b", madd_b, m_last_b);
    check("madd_c", madd_c, m_last_c);
    cyc++;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sb.size() > 0; k++) step('0, 1'b1);
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      a_pk[i*32 +: 32] = $urandom;
      b_pk[i*32 +: 32] = $urandom;
      c_pk[i*32 +: 32] = $urandom;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t vt[6];
    int order[6];
    int hs_cnt, pops, first_pop, resume;

    // reset state, with requests pending to show ready stays low
    rst = 1'b1;
    rand_ops();
    bus.req_valid = '1; bus.req_a = a_pk; bus.req_b = b_pk; bus.req_c = c_pk;
    bus.rsp_ready = 1'b1;
    #12;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_z", bus.rsp_z, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_madd_a", madd_a, 0);
    bus.req_valid = '0;
    @(negedge clk) rst = 1'b0;

    // all requesters valid: round robin from 0
    order = '{0, 1, 2, 3, 0, 1};
    pop_ids.delete();
    for (int k = 0; k < 6; k++) begin
      rand_ops();
      step('1, 1'b1);
      check("rr_grant", o_gid, order[k]);
    end
    drain();
    check("rr_rsp_count", pop_ids.size(), 6);
    for (int k = 0; k < 6 && k < pop_ids.size(); k++) check("rr_rsp_order", pop_ids[k], order[k]);

    // directed single ops: value and exact latency
    vt[0] = '{0, 32'd3,          32'd5,          32'd7,          32'd22};
    vt[1] = '{2, 32'hFFFF_FFFE,  32'd3,          32'd1,          32'hFFFF_FFFB};
    vt[2] = '{1, 32'h0001_0000,  32'h0001_0000,  32'd5,          32'd5};
    vt[3] = '{3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          32'd1};
    vt[4] = '{1, 32'h7FFF_FFFF,  32'd2,          32'd0,          32'hFFFF_FFFE};
    vt[5] = '{0, 32'd0,          32'd12345,      32'hFFFF_FFFF,  32'hFFFF_FFFF};
    for (int n = 0; n < 6; n++) begin
      rand_ops();
      a_pk[vt[n].id*32 +: 32] = vt[n].a;
      b_pk[vt[n].id*32 +: 32] = vt[n].b;
      c_pk[vt[n].id*32 +: 32] = vt[n].c;
      step(NREQ'(1) << vt[n].id, 1'b1);
      check("vec_handshake", o_hs, 1);
      for (int l = 0; l < LAT; l++) begin
        step('0, 1'b1);
        check("vec_not_early", o_rv, 0);
      end
      step('0, 1'b1);
      check("vec_valid", o_rv, 1);
      check("vec_z", o_z, vt[n].z);
      check("vec_id", o_id, vt[n].id);
    end

    // backpressure: credits run out after FIFO_DEPTH issues
    hs_cnt = 0; pops = 0;
    for (int k = 0; k < 8; k++) begin
      rand_ops();
      step(4'b0010, 1'b0);
      hs_cnt += int'(o_hs);
    end
    check("bp_hs_count", hs_cnt, FIFO_DEPTH);
    check("bp_ready_low", o_rdy, 0);
    first_pop = -1; resume = -1;
    for (int k = 0; k < 12; k++) begin
      rand_ops();
      step(4'b0010, 1'b1);
      if (o_pop) pops++;
      if (o_hs) hs_cnt++;
      if (o_pop && first_pop < 0) first_pop = cyc - 1;
      if (first_pop >= 0 && resume < 0 && o_hs) resume = cyc - 1;
    end
    check("bp_resume_delay", resume - first_pop, 1);
    while (sb.size() > 0 && pops < 100) begin
      step('0, 1'b1);
      if (o_pop) pops++;
    end
    check("bp_no_loss", pops, hs_cnt);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      rand_ops();
      step(NREQ'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
    end
    drain();

    // reset with results buffered and one in flight
    for (int k = 0; k < 3; k++) begin
      rand_ops();
      step(4'b0001, 1'b0);
    end
    @(posedge clk);
    #2;
    check("pre_rst_rsp_valid", bus.rsp_valid, 1);
    rst = 1'b1;
    #1;
    check("arst_req_ready", bus.req_ready, 0);
    check("arst_rsp_valid", bus.rsp_valid, 0);
    check("arst_rsp_z", bus.rsp_z, 0);
    check("arst_rsp_id", bus.rsp_id, 0);
    check("arst_madd_a", madd_a, 0);
    check("arst_madd_b", madd_b, 0);
    check("arst_madd_c", madd_c, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = '0;
    sb.delete();
    m_rr = 0; m_last_a = '0; m_last_b = '0; m_last_c = '0;
    for (int k = 0; k < 3; k++) step('0, 1'b1);
    a_pk[31:0] = 32'd1; b_pk[31:0] = 32'd1; c_pk[31:0] = 32'd1;
    step(4'b0001, 1'b1);
    check("post_rst_hs", o_hs, 1);
    for (int l = 0; l < LAT; l++) step('0, 1'b1);
    step('0, 1'b1);
    check("post_rst_valid", o_rv, 1);
    check("post_rst_z", o_z, 2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
